// File: rtl/fp4_fft_pkg.sv
// Shared definitions for the FP4 FFT result unloader.
//   - unl_state_e : unloader FSM states
//   - RD_LATENCY  : cycles from an issued read address to usable read data
//   - FIFO_DEPTH  : entries in the output skid FIFO (also the read credit limit)
//   - RE_*/IM_*   : bit positions of the real/imaginary FP4 fields in a word
package fp4_fft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } unl_state_e;

  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned FIFO_DEPTH = 2;

  localparam int unsigned RE_MSB = 7;
  localparam int unsigned RE_LSB = 4;
  localparam int unsigned IM_MSB = 3;
  localparam int unsigned IM_LSB = 0;

endpackage

// File: rtl/fp4_skid_fifo.sv
// Two-entry first-word-fall-through FIFO used as the output skid buffer.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-low reset
//   push, push_data write an entry (ignored when full and not popping)
//   pop             remove the head entry (ignored when empty)
//   head            current head entry, valid whenever !empty
//   empty           no entries held
//   count           number of entries held (0..2)
module fp4_skid_fifo
  import fp4_fft_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] ent0_q;
  logic [WIDTH-1:0] ent1_q;
  logic [1:0]       cnt_q;
  logic             do_pop;

  assign do_pop = pop && (cnt_q != 2'd0);

  // ent0_q is always the head; it only changes on a pop or on a push into an
  // empty FIFO, which keeps the head stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            ent0_q <= push_data;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && do_pop) begin
            ent0_q <= push_data;
          end else if (push) begin
            ent1_q <= push_data;
            cnt_q  <= 2'd2;
          end else if (do_pop) begin
            cnt_q  <= 2'd0;
          end
        end
        default: begin
          if (do_pop) begin
            ent0_q <= ent1_q;
            if (push) begin
              ent1_q <= push_data;
            end else begin
              cnt_q <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign head  = ent0_q;
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;

  logic unused_depth;
  assign unused_depth = (FIFO_DEPTH == 2);

endmodule

// File: rtl/fp4_fft_unloader.sv
// Drains MAX_N FP4 FFT result words from the ping-pong memory in natural
// order after fft_done and presents them as a valid/ready stream.
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-low reset
//   fft_done      one-cycle pulse that starts a drain (only honoured in IDLE)
//   rd_addr       external memory read address
//   rd_data       memory word for the address presented in the previous cycle
//   m_valid/m_ready/m_data/m_index/m_last  output stream, {re,im} word + bin
//   busy          high while a drain is in progress
//   unload_done   one-cycle pulse after the final handshake
module fp4_fft_unloader
  import fp4_fft_pkg::*;
#(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fft_done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            m_data,
  output logic [ADDR_WIDTH-1:0] m_index,
  output logic                  m_last,
  output logic                  busy,
  output logic                  unload_done
);

  localparam int FW = 8 + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   LAST_PTR = (ADDR_WIDTH+1)'(MAX_N - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAX_N - 1);

  unl_state_e            state_q;
  logic [ADDR_WIDTH:0]   issue_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [RD_LATENCY-1:0] inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_idx_q;
  logic                  busy_q;
  logic                  done_q;

  logic [FW-1:0]         push_data;
  logic [FW-1:0]         head;
  logic                  empty;
  logic [1:0]            fifo_cnt;
  logic                  pop;
  logic                  issue;
  logic [2:0]            credit_used;
  logic [7:0]            head_word;

  assign pop = !empty && m_ready;

  // Credits count words held plus the read in flight, less the word leaving
  // this cycle. Counting the pop lets the stream sustain one word per cycle
  // while still never pushing into a full FIFO when the consumer stalls.
  assign credit_used = {1'b0, fifo_cnt} + {2'b00, inflight_q[0]} - {2'b00, pop};
  assign issue       = (state_q == STREAM) && (credit_used < 3'(FIFO_DEPTH));

  // The address is presented in the issue cycle so the memory returns the
  // word one cycle later; between issues the last address is held.
  assign rd_addr = issue ? issue_ptr_q[ADDR_WIDTH-1:0] : rd_addr_q;

  assign push_data = {rd_data, inflight_idx_q, (inflight_idx_q == LAST_IDX)};

  fp4_skid_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q[0]),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      issue_ptr_q    <= '0;
      rd_addr_q      <= '0;
      inflight_q     <= '0;
      inflight_idx_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= RD_LATENCY'(issue);
      if (issue) begin
        rd_addr_q      <= issue_ptr_q[ADDR_WIDTH-1:0];
        inflight_idx_q <= issue_ptr_q[ADDR_WIDTH-1:0];
        issue_ptr_q    <= issue_ptr_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          // done_q blocks a pulse coincident with the previous unload_done.
          if (fft_done && !done_q) begin
            state_q     <= STREAM;
            busy_q      <= 1'b1;
            issue_ptr_q <= '0;
          end
        end
        STREAM: begin
          if (issue && (issue_ptr_q == LAST_PTR)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state_q <= DONE;
          end
        end
        default: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign head_word   = head[FW-1 -: 8];
  assign m_valid     = !empty;
  assign m_data      = {head_word[RE_MSB:RE_LSB], head_word[IM_MSB:IM_LSB]};
  assign m_index     = head[ADDR_WIDTH:1];
  assign m_last      = head[0];
  assign busy        = busy_q;
  assign unload_done = done_q;

endmodule

// File: tb/tb_fp4_fft_unloader.sv
module tb_fp4_fft_unloader;

  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fft_done = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [7:0]    m_data;
  logic [AW-1:0] m_index;
  logic          m_last;
  logic          busy;
  logic          unload_done;

  logic          fft_done2 = 1'b0;
  logic [0:0]    rd_addr2;
  logic [7:0]    rd_data2 = 8'h00;
  logic          m_valid2;
  logic          m_ready2 = 1'b1;
  logic [7:0]    m_data2;
  logic [0:0]    m_index2;
  logic          m_last2;
  logic          busy2;
  logic          unload_done2;

  logic [7:0] mem  [N];
  logic [7:0] mem2 [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    int         idx;
    bit         last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   t0, got, done_cnt, first_v, done_cyc;
  bit   mon_en = 1'b0;
  bit   stall_chk = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0]    prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_last;

  fp4_fft_unloader #(.MAX_N(N)) dut (
    .clk(clk), .rst(rst), .fft_done(fft_done), .rd_addr(rd_addr),
    .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .busy(busy), .unload_done(unload_done)
  );

  fp4_fft_unloader #(.MAX_N(2)) dut2 (
    .clk(clk), .rst(rst), .fft_done(fft_done2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .m_index(m_index2), .m_last(m_last2), .busy(busy2), .unload_done(unload_done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_data  <= mem[rd_addr];
    rd_data2 <= mem2[rd_addr2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Stream scoreboard: every handshake must match the next expected word,
  // and a stalled word must stay put until accepted.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data",  32'(m_data),  32'(prev_data));
        check("hold_index", 32'(m_index), 32'(prev_idx));
        check("hold_last",  32'(m_last),  32'(prev_last));
      end
      if (stall_chk && (cyc - t0) < 10)
        check("stall_rd_addr_le1", 32'(rd_addr <= 1), 32'd1);
      if (m_valid && first_v < 0) first_v = cyc - t0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(m_index), 32'hFFFF_FFFF);
        end else begin
          e_mon = exp_q.pop_front();
          check("data",  32'(m_data),  32'(e_mon.d));
          check("index", 32'(m_index), 32'(e_mon.idx));
          check("last",  32'(m_last),  32'(e_mon.last));
        end
        got++;
      end
      if (unload_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc - t0;
        check("busy_low_at_done", 32'(busy), 32'd0);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_idx   = m_index;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      2:       return k >= 10;
      default: return 1'($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_valid"},     32'(m_valid),     32'd0);
    check({tag, "_m_data"},      32'(m_data),      32'd0);
    check({tag, "_m_index"},     32'(m_index),     32'd0);
    check({tag, "_m_last"},      32'(m_last),      32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_unload_done"}, 32'(unload_done), 32'd0);
    check({tag, "_rd_addr"},     32'(rd_addr),     32'd0);
  endtask

  // mode: m_ready pattern; repulse_at/abort_at: output index at which to
  // pulse fft_done again or pull reset (-1 disables).
  task automatic run_drain(input int mode, input int repulse_at, input int abort_at);
    int  k;
    bit  repulsed;
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      e.d = mem[i]; e.idx = i; e.last = (i == N - 1);
      exp_q.push_back(e);
    end
    got = 0; done_cnt = 0; first_v = -1; done_cyc = -1;
    repulsed = 1'b0;
    @(posedge clk); #1;
    fft_done = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
    t0 = cyc;
    mon_en = 1'b1;
    k = 0;
    while (done_cnt == 0 && k < 400) begin
      m_ready  = ready_for(mode, k);
      fft_done = 1'b0;
      if (repulse_at >= 0 && got == repulse_at && !repulsed) begin
        fft_done = 1'b1;
        repulsed = 1'b1;
      end
      if (mode == 2 && k == 9) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_word0", 32'(m_data),  32'd0);
      end
      if (abort_at >= 0 && got == abort_at) begin
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        m_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("post_reset_valid", 32'(m_valid), 32'd0);
          check("post_reset_busy",  32'(busy),    32'd0);
        end
        return;
      end
      @(posedge clk); #1;
      k++;
    end
    fft_done = 1'b0;
    m_ready  = 1'b1;
    check("done_seen", 32'(done_cnt > 0), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    mon_en = 1'b0;
    stall_chk = 1'b0;
    check("word_count",     32'(got),           32'(N));
    check("words_left",     32'(exp_q.size()),  32'd0);
    check("done_pulses",    32'(done_cnt),      32'd1);
    check("busy_after",     32'(busy),          32'd0);
    if (mode == 0) begin
      check("first_valid_latency", 32'(first_v),  32'd2);
      check("done_latency",        32'(done_cyc), 32'(N + 3));
    end
  endtask

  initial begin
    int n2, done2, t2;
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    mem2[0] = 8'hA5;
    mem2[1] = 8'h3C;

    #2;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // 1: full rate
    run_drain(0, -1, -1);
    // 2: alternating ready
    run_drain(1, -1, -1);
    // 3: consumer stalled for 10 cycles
    stall_chk = 1'b1;
    run_drain(2, -1, -1);
    // 4: second fft_done mid-drain is ignored
    run_drain(0, 5, -1);
    // 5: reset at output index 12, then a full drain from scratch
    run_drain(0, -1, 12);
    run_drain(0, -1, -1);
    // random data with random backpressure
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      run_drain(3, -1, -1);
    end

    // 6: MAX_N=2 instance
    n2 = 0; done2 = -1;
    @(posedge clk); #1;
    fft_done2 = 1'b1;
    @(posedge clk); #1;
    fft_done2 = 1'b0;
    t2 = cyc;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid2 && m_ready2) begin
        if (n2 == 0) begin
          check("n2_data0", 32'(m_data2), 32'hA5);
          check("n2_last0", 32'(m_last2), 32'd0);
        end else begin
          check("n2_data1", 32'(m_data2), 32'h3C);
          check("n2_last1", 32'(m_last2), 32'd1);
        end
        n2++;
      end
      if (unload_done2 && done2 < 0) done2 = cyc - t2;
    end
    check("n2_count",        32'(n2),    32'd2);
    check("n2_done_latency", 32'(done2), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
